// File: rtl/chacha20_byte_packer.sv
// chacha20_byte_packer: packs a valid/ready/last byte stream into 32*DATA_WIDTH_WORDS-bit words
// with a keep mask; a completed word waits in the accumulator when the output register is busy.
module chacha20_byte_packer #(
   parameter int DATA_WIDTH_WORDS = 1,
   parameter int ENDIANNESS = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [7:0]                     in_byte,
   input  logic                           in_valid,
   input  logic                           in_last,
   output logic                           in_ready,
   output logic [32*DATA_WIDTH_WORDS-1:0] out_data,
   output logic [4*DATA_WIDTH_WORDS-1:0]  out_keep,
   output logic                           out_valid,
   output logic                           out_last,
   input  logic                           out_ready,
   output logic [31:0]                    word_count
);
   localparam int L = 4*DATA_WIDTH_WORDS;
   localparam int DW = 32*DATA_WIDTH_WORDS;
   localparam int IW = $clog2(L);
   logic [DW-1:0] acc_data, nxt_data;
   logic [L-1:0]  acc_keep, nxt_keep;
   logic [IW-1:0] idx;
   logic          hold, hold_last, out_free, accept, complete;
   function automatic int lane_off(input int i);
      return 32*(i/4) + ((ENDIANNESS != 0) ? 8*(3 - i%4) : 8*(i%4));
   endfunction
   assign in_ready = !hold;
   assign out_free = !out_valid || out_ready;
   assign accept   = in_valid && !hold;
   assign complete = accept && (in_last || idx == IW'(L-1));
   always_comb begin
      nxt_data = acc_data;
      nxt_keep = acc_keep;
      for (int i = 0; i < L; i++) begin
         if (idx == IW'(i)) begin
            nxt_data[lane_off(i) +: 8] = in_byte;
            nxt_keep[i] = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data   <= '0;
         out_keep   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         word_count <= '0;
         acc_data   <= '0;
         acc_keep   <= '0;
         idx        <= '0;
         hold       <= 1'b0;
         hold_last  <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            word_count <= word_count + 32'd1;
         end
         // a held word has priority; no byte is accepted while holding
         if (hold && out_free) begin
            out_data  <= acc_data;
            out_keep  <= acc_keep;
            out_last  <= hold_last;
            out_valid <= 1'b1;
            acc_data  <= '0;
            acc_keep  <= '0;
            hold      <= 1'b0;
         end else if (complete) begin
            if (out_free) begin
               out_data  <= nxt_data;
               out_keep  <= nxt_keep;
               out_last  <= in_last;
               out_valid <= 1'b1;
               acc_data  <= '0;
               acc_keep  <= '0;
            end else begin
               acc_data  <= nxt_data;
               acc_keep  <= nxt_keep;
               hold      <= 1'b1;
               hold_last <= in_last;
            end
            idx <= '0;
         end else if (accept) begin
            acc_data <= nxt_data;
            acc_keep <= nxt_keep;
            idx      <= idx + 1'b1;
         end
      end
   end
endmodule
